// File: rtl/microwave_timer_if.sv
// Bundle of the keypad/door front-end and counter-chain signals seen by the
// microwave timer controller. The controller binds the slave modport; the
// front end / chain side binds the master modport.
interface microwave_timer_if;
  logic        one_hz;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        start;
  logic        stop;
  logic        door_closed;
  logic        zero_in;
  logic [15:0] load_data;
  logic        loadn;
  logic        en;
  logic        mag_on;
  logic        done;
  logic [2:0]  state;

  modport master (
    output one_hz, digit_in, digit_valid, start, stop, door_closed, zero_in,
    input  load_data, loadn, en, mag_on, done, state
  );

  modport slave (
    input  one_hz, digit_in, digit_valid, start, stop, door_closed, zero_in,
    output load_data, loadn, en, mag_on, done, state
  );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// Microwave MM:SS timer sequencer: collects keypad digits into a BCD preset,
// loads it into the external countdown chain, gates the 1 Hz tick while
// cooking, enforces door/stop/start interlocks and signals cook completion.
module microwave_timer_ctrl #(
  parameter int DONE_TICKS = 3
) (
  input logic              clk,
  input logic              clrn,
  microwave_timer_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_COOK  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int CW = (DONE_TICKS < 2) ? 1 : $clog2(DONE_TICKS);
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TICKS - 1);

  logic [2:0]    r_state;
  logic [15:0]   r_entry;
  logic          r_cancel;
  logic [CW-1:0] r_done_cnt;
  logic          r_loadn;
  logic          r_mag_on;
  logic          r_done;

  logic [2:0]    w_state;
  logic [15:0]   w_entry;
  logic          w_cancel;
  logic [CW-1:0] w_done_cnt;
  logic          w_digit_ok;
  logic          w_start_ok;

  assign w_digit_ok = bus.digit_valid && (bus.digit_in <= 4'd9);
  // A start is only honoured with the door shut, a non-empty preset and
  // legal seconds tens (the chain's tens digit wraps at 5).
  assign w_start_ok = bus.start && bus.door_closed && (r_entry != 16'h0000)
                      && (r_entry[7:4] <= 4'd5);

  // Next-state, entry and done-counter logic; priority stop > door > start > digit.
  always_comb begin
    w_state    = r_state;
    w_entry    = r_entry;
    w_cancel   = r_cancel;
    w_done_cnt = r_done_cnt;
    case (r_state)
      S_IDLE: begin
        w_entry = 16'h0000;
        if (bus.stop || bus.start) begin
          w_state = S_IDLE;
        end else if (w_digit_ok) begin
          w_entry = {12'h000, bus.digit_in};
          w_state = S_SET;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_SET: begin
        if (bus.stop) begin
          w_entry = 16'h0000;
          w_state = S_IDLE;
        end else if (bus.start) begin
          if (w_start_ok) begin
            w_cancel = 1'b0;
            w_state  = S_LOAD;
          end else begin
            w_state = S_SET;
          end
        end else if (w_digit_ok) begin
          w_entry = {r_entry[11:0], bus.digit_in};
        end else begin
          w_state = S_SET;
        end
      end
      S_LOAD: begin
        // A cancel load zeroes the chain and returns home instead of cooking.
        w_cancel = 1'b0;
        w_state  = r_cancel ? S_IDLE : S_COOK;
      end
      S_COOK: begin
        // Expiry wins over stop/door: the time is already used up.
        if (bus.zero_in) begin
          w_entry    = 16'h0000;
          w_done_cnt = '0;
          w_state    = S_DONE;
        end else if (bus.stop || !bus.door_closed) begin
          w_state = S_PAUSE;
        end else begin
          w_state = S_COOK;
        end
      end
      S_PAUSE: begin
        if (bus.stop) begin
          w_entry  = 16'h0000;
          w_cancel = 1'b1;
          w_state  = S_LOAD;
        end else if (!bus.door_closed) begin
          w_state = S_PAUSE;
        end else if (bus.start) begin
          w_state = S_COOK;
        end else begin
          w_state = S_PAUSE;
        end
      end
      S_DONE: begin
        if (bus.stop || bus.start || !bus.door_closed) begin
          w_done_cnt = '0;
          w_state    = S_IDLE;
        end else if (bus.one_hz) begin
          if (r_done_cnt == DONE_LAST) begin
            w_done_cnt = '0;
            w_state    = S_IDLE;
          end else begin
            w_done_cnt = r_done_cnt + 1'b1;
          end
        end else begin
          w_state = S_DONE;
        end
      end
      default: begin
        w_entry    = 16'h0000;
        w_cancel   = 1'b0;
        w_done_cnt = '0;
        w_state    = S_IDLE;
      end
    endcase
  end

  // State, entry and registered outputs; outputs decode the upcoming state so
  // they are valid for the whole cycle the FSM spends there.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state    <= S_IDLE;
      r_entry    <= 16'h0000;
      r_cancel   <= 1'b0;
      r_done_cnt <= '0;
      r_loadn    <= 1'b1;
      r_mag_on   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_entry    <= w_entry;
      r_cancel   <= w_cancel;
      r_done_cnt <= w_done_cnt;
      r_loadn    <= (w_state != S_LOAD);
      r_mag_on   <= (w_state == S_COOK);
      r_done     <= (w_state == S_DONE);
    end
  end

  assign bus.load_data = r_entry;
  assign bus.loadn     = r_loadn;
  assign bus.mag_on    = r_mag_on;
  assign bus.done      = r_done;
  assign bus.state     = r_state;
  // Tick gate is combinational so an expired chain masks en in the same cycle.
  assign bus.en        = (r_state == S_COOK) && bus.one_hz && !bus.zero_in;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed self-checking bench for microwave_timer_ctrl.
module tb_microwave_timer_ctrl;
  logic clk;
  logic clrn;
  int   total;
  int   bad;

  microwave_timer_if u_if ();

  microwave_timer_ctrl #(.DONE_TICKS(3)) u_dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    u_if.digit_in    = d;
    u_if.digit_valid = 1'b1;
    step();
    u_if.digit_valid = 1'b0;
  endtask

  task automatic press_start();
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
  endtask

  task automatic press_stop();
    u_if.stop = 1'b1;
    step();
    u_if.stop = 1'b0;
  endtask

  task automatic tick_step();
    u_if.one_hz = 1'b1;
    step();
    u_if.one_hz = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clrn             = 1'b0;
    u_if.one_hz      = 1'b0;
    u_if.digit_in    = 4'h0;
    u_if.digit_valid = 1'b0;
    u_if.start       = 1'b0;
    u_if.stop        = 1'b0;
    u_if.door_closed = 1'b1;
    u_if.zero_in     = 1'b0;
    step();
    step();
    clrn = 1'b1;

    // Reset state
    chk("rst_state", 32'(u_if.state), 32'd0);
    chk("rst_load",  32'(u_if.load_data), 32'h0);
    chk("rst_loadn", 32'(u_if.loadn), 32'd1);
    chk("rst_mag",   32'(u_if.mag_on), 32'd0);
    chk("rst_done",  32'(u_if.done), 32'd0);
    chk("rst_en",    32'(u_if.en), 32'd0);

    // Entry
    key(4'd1);
    chk("entry1", 32'(u_if.load_data), 32'h0001);
    key(4'd3);
    key(4'd0);
    chk("entry130", 32'(u_if.load_data), 32'h0130);
    chk("entry_state", 32'(u_if.state), 32'd1);
    key(4'hC);
    chk("entry_badkey", 32'(u_if.load_data), 32'h0130);
    chk("entry_badkey_st", 32'(u_if.state), 32'd1);
    key(4'd2);
    key(4'd4);
    chk("entry_drop", 32'(u_if.load_data), 32'h3024);
    press_stop();
    chk("stop_set_st", 32'(u_if.state), 32'd0);
    chk("stop_set_load", 32'(u_if.load_data), 32'h0);

    // Rejects
    key(4'd7);
    key(4'd5);
    chk("rej75_entry", 32'(u_if.load_data), 32'h0075);
    press_start();
    chk("rej75_state", 32'(u_if.state), 32'd1);
    chk("rej75_loadn", 32'(u_if.loadn), 32'd1);
    press_stop();
    key(4'd1);
    key(4'd0);
    u_if.door_closed = 1'b0;
    press_start();
    chk("rejdoor_state", 32'(u_if.state), 32'd1);
    chk("rejdoor_loadn", 32'(u_if.loadn), 32'd1);
    u_if.door_closed = 1'b1;
    press_stop();

    // Cook to completion
    key(4'd3);
    chk("cook_entry", 32'(u_if.load_data), 32'h0003);
    press_start();
    chk("load_state", 32'(u_if.state), 32'd2);
    chk("load_loadn", 32'(u_if.loadn), 32'd0);
    chk("load_mag", 32'(u_if.mag_on), 32'd0);
    step();
    chk("cook_state", 32'(u_if.state), 32'd3);
    chk("cook_loadn", 32'(u_if.loadn), 32'd1);
    chk("cook_mag", 32'(u_if.mag_on), 32'd1);
    chk("cook_en_idle", 32'(u_if.en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      u_if.one_hz = 1'b1;
      #1;
      chk("cook_en_tick", 32'(u_if.en), 32'd1);
      step();
      u_if.one_hz = 1'b0;
      #1;
      chk("cook_en_low", 32'(u_if.en), 32'd0);
    end
    u_if.zero_in = 1'b1;
    u_if.one_hz  = 1'b1;
    #1;
    chk("zero_mask_en", 32'(u_if.en), 32'd0);
    step();
    u_if.one_hz = 1'b0;
    chk("done_state", 32'(u_if.state), 32'd5);
    chk("done_flag", 32'(u_if.done), 32'd1);
    chk("done_mag", 32'(u_if.mag_on), 32'd0);
    chk("done_entry", 32'(u_if.load_data), 32'h0);
    tick_step();
    tick_step();
    chk("done_hold2", 32'(u_if.done), 32'd1);
    chk("done_hold2_st", 32'(u_if.state), 32'd5);
    tick_step();
    chk("done_end_st", 32'(u_if.state), 32'd0);
    chk("done_end_flag", 32'(u_if.done), 32'd0);
    u_if.zero_in = 1'b0;

    // Pause / resume
    key(4'd1);
    key(4'd0);
    press_start();
    step();
    chk("pr_cook", 32'(u_if.state), 32'd3);
    u_if.door_closed = 1'b0;
    #1;
    chk("pr_mag_still", 32'(u_if.mag_on), 32'd1);
    step();
    chk("pr_pause_st", 32'(u_if.state), 32'd4);
    chk("pr_pause_mag", 32'(u_if.mag_on), 32'd0);
    u_if.one_hz = 1'b1;
    #1;
    chk("pr_pause_en", 32'(u_if.en), 32'd0);
    step();
    u_if.one_hz = 1'b0;
    chk("pr_pause_hold", 32'(u_if.state), 32'd4);
    u_if.door_closed = 1'b1;
    press_start();
    chk("pr_resume_st", 32'(u_if.state), 32'd3);
    chk("pr_resume_loadn", 32'(u_if.loadn), 32'd1);
    chk("pr_resume_mag", 32'(u_if.mag_on), 32'd1);
    chk("pr_resume_data", 32'(u_if.load_data), 32'h0010);

    // Cancel from pause
    press_stop();
    chk("cn_pause", 32'(u_if.state), 32'd4);
    press_stop();
    chk("cn_load_st", 32'(u_if.state), 32'd2);
    chk("cn_loadn", 32'(u_if.loadn), 32'd0);
    chk("cn_data", 32'(u_if.load_data), 32'h0);
    step();
    chk("cn_idle", 32'(u_if.state), 32'd0);
    chk("cn_loadn_hi", 32'(u_if.loadn), 32'd1);

    // Zero and stop together in COOK
    key(4'd5);
    press_start();
    step();
    u_if.zero_in = 1'b1;
    press_stop();
    chk("zs_done", 32'(u_if.state), 32'd5);
    chk("zs_doneflag", 32'(u_if.done), 32'd1);
    u_if.zero_in = 1'b0;
    press_stop();
    chk("zs_idle", 32'(u_if.state), 32'd0);
    chk("zs_doneclr", 32'(u_if.done), 32'd0);

    // Reset mid-cook
    key(4'd5);
    press_start();
    step();
    chk("rm_cook", 32'(u_if.mag_on), 32'd1);
    clrn = 1'b0;
    step();
    clrn = 1'b1;
    chk("rm_state", 32'(u_if.state), 32'd0);
    chk("rm_mag", 32'(u_if.mag_on), 32'd0);
    chk("rm_loadn", 32'(u_if.loadn), 32'd1);
    chk("rm_data", 32'(u_if.load_data), 32'h0);
    key(4'd7);
    chk("rm_digit", 32'(u_if.load_data), 32'h0007);
    chk("rm_set", 32'(u_if.state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
